// File: rtl/irb_pkg.sv
// irb_pkg: shared constants and state type for the expansion-kernel RAM controller
package irb_pkg;
  localparam int KEX_N_ELEM = 288;
  localparam int KEX_DW = 10;
  typedef enum logic [1:0] {IDLE, LOAD, READY, READ} kex_state_t;
endpackage

// File: rtl/kex_addr_gen.sv
// kex_addr_gen: base/length address counter wrapping at N_ELEM, holds when not advancing
module kex_addr_gen import irb_pkg::*; #(
  parameter int N_ELEM = KEX_N_ELEM,
  parameter int AW = $clog2(N_ELEM + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_adv,
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_len,
  output logic [AW-1:0] o_addr,
  output logic [AW-1:0] o_prv,
  output logic [AW-1:0] o_len,
  output logic          o_last,
  output logic          o_done
);
  localparam logic [AW-1:0] LAST_A = AW'(N_ELEM - 1);
  logic [AW-1:0] r_addr, r_prv, r_cnt, r_len;
  // Restart on a new transfer; otherwise step the address and count on each advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_prv <= '0;
      r_cnt <= '0;
      r_len <= '0;
    end else if (i_start) begin
      r_addr <= i_base;
      r_prv <= i_base;
      r_cnt <= '0;
      r_len <= i_len;
    end else if (i_adv) begin
      r_prv <= r_addr;
      r_addr <= r_addr == LAST_A ? '0 : r_addr + AW'(1);
      r_cnt <= r_cnt + AW'(1);
    end
  end
  assign o_addr = r_addr;
  assign o_prv = r_prv;
  assign o_len = r_len;
  assign o_last = r_cnt == r_len - AW'(1);
  assign o_done = r_cnt == r_len;
endmodule

// File: rtl/kex_ram_ctrl.sv
// kex_ram_ctrl: sole master of the expansion-kernel tile RAM; loads from the loader stream, serves ranged read bursts
// Optional KEX_CTRL_CHECK_EN adds a sticky err output flagging protocol violations.
module kex_ram_ctrl import irb_pkg::*; #(
  parameter int N_ELEM = KEX_N_ELEM,
  parameter int DW = KEX_DW,
  parameter int AW = $clog2(N_ELEM + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_len,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          rd_start,
  input  logic [AW-1:0] rd_base,
  input  logic [AW-1:0] rd_len,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_write,
  input  logic [DW-1:0] ram_res,
  output logic          tile_loaded,
  output logic          busy
`ifdef KEX_CTRL_CHECK_EN
  ,
  output logic          err
`endif
);
  localparam logic [AW-1:0] NW = AW'(N_ELEM);
  kex_state_t r_state;
  logic r_valid;
  logic [AW-1:0] r_out_cnt;
  logic [AW-1:0] w_ld_len, w_rd_len, w_rd_base, w_gen_addr, w_gen_prv, w_gen_len;
  logic w_ld_acc, w_rd_acc, w_hs_ld, w_hs_rd, w_stall, w_adv, w_gen_last, w_gen_done;
  assign w_ld_len = (ld_len == '0 || ld_len > NW) ? NW : ld_len;
  assign w_rd_len = (rd_len == '0 || rd_len > NW) ? NW : rd_len;
  assign w_rd_base = rd_base >= NW ? rd_base - NW : rd_base;
  assign w_ld_acc = ld_start && (r_state == IDLE || r_state == READY);
  assign w_rd_acc = rd_start && !ld_start && r_state == READY;
  assign w_hs_ld = r_state == LOAD && ld_valid;
  assign w_hs_rd = r_valid && rd_ready;
  assign w_stall = r_valid && !rd_ready;
  assign w_adv = r_state == LOAD ? w_hs_ld : (r_state == READ && !w_stall && !w_gen_done);
  kex_addr_gen #(.N_ELEM(N_ELEM), .AW(AW)) u_gen (
    .clk(clk),
    .rst(rst),
    .i_start(w_ld_acc || w_rd_acc),
    .i_adv(w_adv),
    .i_base(w_ld_acc ? '0 : w_rd_base),
    .i_len(w_ld_acc ? w_ld_len : w_rd_len),
    .o_addr(w_gen_addr),
    .o_prv(w_gen_prv),
    .o_len(w_gen_len),
    .o_last(w_gen_last),
    .o_done(w_gen_done)
  );
  // Sequence the controller and track the one-deep read pipeline behind the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_out_cnt <= '0;
    end else begin
      r_state <= w_ld_acc ? LOAD : w_rd_acc ? READ :
                 ((w_hs_ld && w_gen_last) || (w_hs_rd && rd_last)) ? READY : r_state;
      r_valid <= r_state == READ && (w_stall || !w_gen_done);
      r_out_cnt <= w_rd_acc ? '0 : w_hs_rd ? r_out_cnt + AW'(1) : r_out_cnt;
    end
  end
  assign ld_ready = r_state == LOAD;
  assign ram_write = w_hs_ld;
  assign ram_data = w_hs_ld ? ld_data : '0;
  assign ram_addr = r_state == LOAD ? w_gen_addr : r_state == READ ? (w_stall ? w_gen_prv : w_gen_addr) : '0;
  assign rd_data = ram_res;
  assign rd_valid = r_valid;
  assign rd_last = r_valid && r_out_cnt == w_gen_len - AW'(1);
  assign tile_loaded = (r_state == READY && !ld_start) || r_state == READ;
  assign busy = r_state == LOAD || r_state == READ;
`ifdef KEX_CTRL_CHECK_EN
  logic r_err;
  // Latch any protocol violation until reset.
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if ((ld_valid && r_state != LOAD) || (rd_start && r_state != READY) ||
             (w_ld_acc && (ld_len == '0 || ld_len > NW)) ||
             (w_rd_acc && (rd_len == '0 || rd_len > NW || rd_base >= NW))) r_err <= 1'b1;
  end
  assign err = r_err;
`endif
endmodule

// File: tb/tb_kex_ram_ctrl.sv
// tb_kex_ram_ctrl: randomized scoreboard bench for kex_ram_ctrl with a tile RAM model
module tb_kex_ram_ctrl;
  localparam int N = 288;
  localparam int DW = 10;
  localparam int AW = $clog2(N + 1);

  logic clk = 0, rst = 1;
  logic ld_start = 0, ld_valid = 0, ld_ready;
  logic [AW-1:0] ld_len = '0, rd_base = '0, rd_len = '0, ram_addr;
  logic [DW-1:0] ld_data = '0, rd_data, ram_data, ram_res;
  logic rd_start = 0, rd_valid, rd_ready = 1, rd_last, ram_write, tile_loaded, busy;

  kex_ram_ctrl dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .rd_start(rd_start), .rd_base(rd_base),
    .rd_len(rd_len), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_last(rd_last), .ram_addr(ram_addr), .ram_data(ram_data), .ram_write(ram_write),
    .ram_res(ram_res), .tile_loaded(tile_loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:N-1];
  logic [DW-1:0] model_mem [0:N-1];
  always @(posedge clk) begin
    if (ram_write) ram[ram_addr] <= ram_data;
    ram_res <= ram[ram_addr];
  end

  int checks = 0, errors = 0;
  logic [AW+DW-1:0] exp_wr_q [$];
  logic [DW:0] exp_rd_q [$];
  logic [AW+DW-1:0] ew;
  logic [DW:0] er;
  logic prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_hold_data", rd_data, prev_data);
        chk("stall_hold_valid", rd_valid, 1);
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data = rd_data;
      if (ram_write) begin
        if (exp_wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          ew = exp_wr_q.pop_front();
          chk("wr_addr", ram_addr, ew[AW+DW-1:DW]);
          chk("wr_data", ram_data, ew[DW-1:0]);
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd_q.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          er = exp_rd_q.pop_front();
          chk("rd_data", rd_data, er[DW-1:0]);
          chk("rd_last", rd_last, er[DW]);
        end
      end
    end else prev_stall = 0;
  end

  task automatic check_zero(input string nm);
    chk({nm, "_ld_ready"}, ld_ready, 0);
    chk({nm, "_rd_valid"}, rd_valid, 0);
    chk({nm, "_rd_last"}, rd_last, 0);
    chk({nm, "_ram_write"}, ram_write, 0);
    chk({nm, "_tile_loaded"}, tile_loaded, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_ram_addr"}, ram_addr, 0);
    chk({nm, "_ram_data"}, ram_data, 0);
  endtask

  // mode 0: fixed 0x11.., mode 1: random, mode 2: distinct pattern
  task automatic do_load(input int len, input bit gap, input int mode);
    int eff = (len == 0 || len > N) ? N : len;
    int k = $urandom_range(0, 1023);
    logic [DW-1:0] d;
    @(posedge clk); #1;
    ld_start = 1; ld_len = AW'(len);
    @(posedge clk); #1;
    ld_start = 0;
    chk("load_ld_ready", ld_ready, 1);
    chk("load_busy", busy, 1);
    chk("load_tile_loaded", tile_loaded, 0);
    for (int i = 0; i < eff; i++) begin
      if (gap && i > 0) begin
        ld_valid = 0;
        @(posedge clk); #1;
      end
      d = mode == 0 ? DW'(8'h11 + i) : mode == 1 ? DW'($urandom_range(0, 1023)) : DW'((i * 7 + k) % 1024);
      ld_valid = 1; ld_data = d;
      exp_wr_q.push_back({AW'(i), d});
      model_mem[i] = d;
      @(posedge clk); #1;
    end
    ld_valid = 0;
    chk("load_end_ld_ready", ld_ready, 0);
    chk("load_end_tile_loaded", tile_loaded, 1);
    chk("load_end_busy", busy, 0);
  endtask

  // mode 0: rd_ready always 1, mode 1: random, mode 2: 3-cycle stall on word 2
  task automatic do_read(input int base, input int len, input int mode, input bit timing);
    int eff_len = (len == 0 || len > N) ? N : len;
    int eff_base = base % N;
    int hs = 0, cyc = 0, stall_left = 3;
    for (int i = 0; i < eff_len; i++)
      exp_rd_q.push_back({i == eff_len - 1, model_mem[(eff_base + i) % N]});
    @(posedge clk); #1;
    rd_start = 1; rd_base = AW'(base); rd_len = AW'(len); rd_ready = 1;
    while (hs < eff_len && cyc < 4 * eff_len + 20) begin
      @(posedge clk); #1;
      cyc++;
      rd_start = 0;
      if (cyc == 1) chk("rd_first_cycle_valid", rd_valid, 0);
      rd_ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(0, 3) != 0) : !(hs == 2 && rd_valid && stall_left > 0);
      if (mode == 2 && !rd_ready) stall_left--;
      @(negedge clk);
      if (rd_valid && rd_ready) hs++;
    end
    chk("rd_words_done", hs, eff_len);
    if (timing) chk("rd_cycles", cyc, eff_len + 1);
    @(posedge clk); #1;
    rd_ready = 1;
    chk("rd_end_busy", busy, 0);
    chk("rd_end_rd_valid", rd_valid, 0);
    chk("rd_end_tile_loaded", tile_loaded, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin ram[i] = '0; model_mem[i] = '0; end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_zero("reset");
    // rd_start in IDLE must be ignored
    rd_start = 1; rd_len = 4;
    @(posedge clk); #1;
    rd_start = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_rd_ignored_valid", rd_valid, 0);
      chk("idle_rd_ignored_busy", busy, 0);
    end
    do_load(4, 0, 0);
    do_read(0, 4, 0, 1);
    do_load(3, 1, 1);
    do_read(0, 3, 0, 1);
    do_load(0, 0, 2);
    do_read(0, N, 0, 1);
    do_read(N - 2, 4, 0, 1);
    do_read(0, 5, 2, 0);
    do_read(N + 5, 0, 0, 0);
    // ld_start and rd_start together in READY: load wins
    @(posedge clk); #1;
    ld_start = 1; rd_start = 1; ld_len = 10;
    #1 chk("both_start_tile_drop", tile_loaded, 0);
    @(posedge clk); #1;
    ld_start = 0; rd_start = 0;
    chk("both_start_ld_ready", ld_ready, 1);
    chk("both_start_rd_valid", rd_valid, 0);
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1; ld_data = DW'($urandom_range(0, 1023));
      if (i == 4) rd_start = 1;
      exp_wr_q.push_back({AW'(i), ld_data});
      model_mem[i] = ld_data;
      @(posedge clk); #1;
      rd_start = 0;
    end
    ld_valid = 0;
    chk("reload_tile_loaded", tile_loaded, 1);
    for (int t = 0; t < 12; t++)
      do_read($urandom_range(0, 511), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(1, 24), $urandom_range(0, 2), 0);
    // reset mid-READ
    for (int i = 0; i < 20; i++) exp_rd_q.push_back({i == 19, model_mem[(7 + i) % N]});
    @(posedge clk); #1;
    rd_start = 1; rd_base = 7; rd_len = 20;
    @(posedge clk); #1;
    rd_start = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("mid_read_busy", busy, 1);
    rst = 1;
    exp_rd_q.delete();
    @(posedge clk); #1;
    rst = 0;
    check_zero("mid_read_reset");
    rd_start = 1; rd_base = 0; rd_len = 3;
    @(posedge clk); #1;
    rd_start = 0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_reset_rd_ignored", rd_valid, 0);
      chk("post_reset_busy", busy, 0);
    end
    do_load(6, 0, 1);
    do_read(2, 4, 1, 0);
    repeat (3) @(posedge clk);
    chk("wr_queue_empty", exp_wr_q.size(), 0);
    chk("rd_queue_empty", exp_rd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kex_ram_ctrl.md
Name: kex_ram_ctrl

Overview:
Sequencer owning the address/write port of the 1x1 expansion-kernel tile RAM. Fills the RAM from the off-chip loader stream (valid/ready), then serves ranged read bursts to the expansion-convolution datapath with backpressure. Sits between the DMA/loader, the tile RAM and the expansion PE array; the only master of the RAM.

Parameters:
N_ELEM, 288, RAM depth in words (tile size of expansion kernels)
DW, 10, RAM word width (weight width + clog2(Npar+1))
AW, $clog2(N_ELEM+1), address/count width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ld_start  in  1  pulse: begin tile load
ld_len  in  AW  words to load, sampled on ld_start, 1..N_ELEM
ld_valid  in  1  loader word valid
ld_data  in  DW  loader word
ld_ready  out  1  controller accepts ld_data
rd_start  in  1  pulse: begin read burst
rd_base  in  AW  first address, sampled on rd_start
rd_len  in  AW  burst length, sampled on rd_start, 1..N_ELEM
rd_data  out  DW  read word (RAM output routed through)
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts rd_data
rd_last  out  1  with rd_valid: final word of burst
ram_addr  out  AW  RAM address
ram_data  out  DW  RAM write data
ram_write  out  1  RAM write enable
ram_res  in  DW  RAM registered read data (1-cycle latency)
tile_loaded  out  1  tile resident and readable
busy  out  1  state != IDLE/READY

Behaviour:
- Reset: state IDLE; ld_ready, rd_valid, rd_last, ram_write, tile_loaded, busy = 0; ram_addr, ram_data = 0; counters cleared. Reset mid-LOAD/READ aborts without completion; tile_loaded stays 0.
- FSM: IDLE -> LOAD on ld_start. LOAD -> READY when ld_len-th word accepted. READY -> READ on rd_start; READ -> READY after rd_len-th word handshaken. READY -> LOAD on ld_start (reload; tile_loaded drops to 0 that cycle).
- rd_start in IDLE/LOAD ignored; ld_start in LOAD/READ ignored; ld_start and rd_start together in READY: ld_start wins.
- LOAD: ld_ready = 1. Each ld_valid&&ld_ready: ram_write=1, ram_addr=wr_cnt, ram_data=ld_data combinationally same cycle; wr_cnt++. ld_ready deasserts the cycle after the last word. tile_loaded=1 from cycle after last write.
- READ: ram_write=0. Issue rd_base in cycle after rd_start; rd_valid rises next cycle (1-cycle RAM latency); rd_data = ram_res.
- Advance: address increments each cycle unless stalled (rd_valid && !rd_ready). While stalled, ram_addr = address of word currently on rd_data so ram_res stays stable; no skid buffer.
- Throughput 1 word/cycle with rd_ready=1; burst of L words completes L+1 cycles after rd_start.
- rd_last = rd_valid && (out_cnt == rd_len-1).
- Address wrap: rd_base+i >= N_ELEM wraps modulo N_ELEM (kernel-row rotation).
- ld_len/rd_len 0 or > N_ELEM: clamp to N_ELEM; rd_base >= N_ELEM taken modulo N_ELEM.

Optional Feature:
KEX_CTRL_CHECK_EN: adds output err (1 bit, sticky until rst), set on: ld_valid outside LOAD, rd_start while not READY, ld_len/rd_len out of range, rd_base >= N_ELEM. Without macro: no err port, violations silently ignored/clamped as above.

Decomposition:
- irb_pkg: kex_state_t enum (IDLE, LOAD, READY, READ), KEX_N_ELEM, word-width constant; parameter defaults sourced from it.
- One sub-module natural: kex_addr_gen (base/length/wrap counter with stall hold), shared by load and read paths.

Test Plan:
- ld_start, ld_len=4, words 0x11..0x14 back-to-back -> ram_write at addr 0..3 on 4 consecutive cycles, tile_loaded=1 next cycle.
- Load gapped (ld_valid 1,0,1,0...) ld_len=3 -> exactly 3 writes, addrs 0,1,2, ld_ready drops after third.
- Full-load N_ELEM words then rd_start base=0 len=N_ELEM, rd_ready=1 -> rd_data matches all words in order, rd_last only on word N_ELEM-1, done at N_ELEM+1 cycles.
- rd_base=N_ELEM-2, len=4 -> addresses N_ELEM-2, N_ELEM-1, 0, 1.
- Read len=5 with rd_ready low 3 cycles on word 2 -> rd_data stable during stall, no dropped/duplicated words.
- rst asserted mid-READ -> next cycle all outputs 0, state IDLE; rd_start then ignored until reload.
